// File: rtl/t01_debounce_pkg.sv
// Shared constants, width helper and hold-phase encoding for the multi-channel debouncer.
package t01_debounce_pkg;

    localparam int DEF_N_CH         = 4;
    localparam int DEF_TICK_DIV     = 250000;
    localparam int DEF_STABLE_CNT   = 3;
    localparam int DEF_HOLD_TICKS   = 100;
    localparam int DEF_REPEAT_TICKS = 25;

    // Bits needed to hold any value 0..maxVal, never fewer than one.
    function automatic int widthFor(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

    typedef enum logic [1:0] {
        HOLD_OFF,
        HOLD_WAIT,
        HOLD_RPT,
        HOLD_SAT
    } holdState_t;

endpackage

// File: rtl/t01_debounce_chan.sv
// One debounce channel: tick-sampled stability filter, edge pulses and auto-repeat.
module t01_debounce_chan
    import t01_debounce_pkg::*;
#(
    parameter int STABLE_CNT   = DEF_STABLE_CNT,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic sync_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int SW = widthFor(STABLE_CNT - 1);
    localparam int HW = widthFor(HOLD_TICKS - 1);
    localparam int RW = widthFor((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_TICKS - 1);
    localparam logic [RW-1:0] REP_LAST    = RW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
    localparam bit            REPEAT_EN   = (REPEAT_TICKS > 0);

    holdState_t    state_q, state_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          repeat_q, repeat_d;
    logic          disagree;
    logic          flip;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= HOLD_OFF;
            stable_q  <= '0;
            hold_q    <= '0;
            rep_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            stable_q  <= stable_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    assign disagree = (sync_i != level_q);
    assign flip     = tick_i && disagree && (stable_q == STABLE_LAST);

    // A flip tick owns the pulse outputs; hold/repeat only advance on the other ticks.
    always_comb begin
        state_d   = state_q;
        stable_d  = stable_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;

        if (tick_i) begin
            if (!disagree || flip) begin
                stable_d = '0;
            end else begin
                stable_d = stable_q + 1'b1;
            end
        end

        if (flip) begin
            level_d   = ~level_q;
            press_d   = ~level_q;
            release_d = level_q;
            hold_d    = '0;
            rep_d     = '0;
            state_d   = level_q ? HOLD_OFF : HOLD_WAIT;
        end else if (tick_i) begin
            case (state_q)
                HOLD_WAIT: begin
                    if (hold_q == HOLD_LAST) begin
                        repeat_d = REPEAT_EN;
                        state_d  = REPEAT_EN ? HOLD_RPT : HOLD_SAT;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                HOLD_RPT: begin
                    if (rep_q == REP_LAST) begin
                        rep_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/t01_debounce_multi.sv
// Multi-channel button debouncer: per-bit synchronizers, one shared sample prescaler,
// and an independent filter/repeat channel per button.
module t01_debounce_multi
    import t01_debounce_pkg::*;
#(
    parameter int N_CH         = DEF_N_CH,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_CNT   = DEF_STABLE_CNT,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] pb_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] repeat_o
);

    localparam int            PW       = widthFor(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;
    logic [PW-1:0]   preCnt_q, preCnt_d;
    logic            tick;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            preCnt_q <= '0;
        end else begin
            sync1_q  <= pb_i;
            sync2_q  <= sync1_q;
            preCnt_q <= preCnt_d;
        end
    end

    // With TICK_DIV=1 the counter sits at zero and tick stays high every cycle.
    assign tick = (preCnt_q == PRE_LAST);

    always_comb begin
        preCnt_d = preCnt_q + 1'b1;
        if (tick) begin
            preCnt_d = '0;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : gChan
        t01_debounce_chan #(
            .STABLE_CNT  (STABLE_CNT),
            .HOLD_TICKS  (HOLD_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) uChan (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .tick_i   (tick),
            .sync_i   (sync2_q[g]),
            .level_o  (level_o[g]),
            .press_o  (press_o[g]),
            .release_o(release_o[g]),
            .repeat_o (repeat_o[g])
        );
    end

endmodule

// File: tb/tb_t01_debounce_multi.sv
// Self-checking bench: directed scenarios plus random button activity against a tick-level model.
module tb_t01_debounce_multi;

    localparam int NCH = 2;
    localparam int TD  = 4;
    localparam int SC  = 3;
    localparam int HT  = 5;
    localparam int RT  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] pb;
    logic [1:0] level, press, rel, rep;
    logic [1:0] level0, press0, rel0, rep0;

    t01_debounce_multi #(
        .N_CH(NCH), .TICK_DIV(TD), .STABLE_CNT(SC), .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pb_i(pb),
        .level_o(level), .press_o(press), .release_o(rel), .repeat_o(rep)
    );

    t01_debounce_multi #(
        .N_CH(NCH), .TICK_DIV(TD), .STABLE_CNT(SC), .HOLD_TICKS(HT), .REPEAT_TICKS(0)
    ) dutNoRep (
        .clk_i(clk), .rst_i(rst), .pb_i(pb),
        .level_o(level0), .press_o(press0), .release_o(rel0), .repeat_o(rep0)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit sawRep0 = 1'b0;

    // Reference model state: sample-tick phase, 2-cycle input delay, disagreeing-tick runs, ticks held.
    int         phase = 0;
    logic [1:0] s1 = '0, s2 = '0;
    logic [1:0] mLevel = '0, mPress = '0, mRel = '0, mRep = '0;
    int         disRun[2];
    int         held[2];

    task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] expected);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, expected, cyc);
        end
    endtask

    task automatic checkValue(input string tag, input int obs, input int expected);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, expected, cyc);
        end
    endtask

    task automatic modelStep();
        bit tk;
        bit flipped;
        if (rst) begin
            phase = 0; s1 = '0; s2 = '0;
            mLevel = '0; mPress = '0; mRel = '0; mRep = '0;
            for (int c = 0; c < NCH; c++) begin
                disRun[c] = 0;
                held[c]   = 0;
            end
        end else begin
            tk     = (phase == TD - 1);
            phase  = (phase + 1) % TD;
            mPress = '0; mRel = '0; mRep = '0;
            if (tk) begin
                for (int c = 0; c < NCH; c++) begin
                    flipped = 1'b0;
                    if (s2[c] != mLevel[c]) begin
                        disRun[c]++;
                        if (disRun[c] == SC) begin
                            mLevel[c] = ~mLevel[c];
                            disRun[c] = 0;
                            held[c]   = 0;
                            flipped   = 1'b1;
                            if (mLevel[c]) mPress[c] = 1'b1;
                            else           mRel[c]   = 1'b1;
                        end
                    end else begin
                        disRun[c] = 0;
                    end
                    if (!flipped && mLevel[c]) begin
                        held[c]++;
                        if (held[c] == HT || (held[c] > HT && ((held[c] - HT) % RT) == 0))
                            mRep[c] = 1'b1;
                    end
                end
            end
            s2 = s1;
            s1 = pb;
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        cyc++;
        if (rep0 !== 2'b00) sawRep0 = 1'b1;
        checkOutput("level",      level,  mLevel);
        checkOutput("press",      press,  mPress);
        checkOutput("release",    rel,    mRel);
        checkOutput("repeat",     rep,    mRep);
        checkOutput("levelNoRep", level0, mLevel);
        checkOutput("pressNoRep", press0, mPress);
        checkOutput("relNoRep",   rel0,   mRel);
        checkOutput("repNoRep",   rep0,   2'b00);
    endtask

    task automatic applyStimulus(input logic rstV, input logic [1:0] pbV, input int n);
        rst = rstV;
        pb  = pbV;
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic waitPulse(input bit wantRelease, input logic [1:0] mask, input int maxCyc,
                             output int lat, output bit found);
        lat   = 0;
        found = 1'b0;
        while (!found && lat < maxCyc) begin
            stepCycle();
            lat++;
            if (((wantRelease ? rel : press) & mask) != 2'b00) found = 1'b1;
        end
    endtask

    int  lat;
    bit  found;
    int  cntP, cntR, repCount, holdLeft;
    bit  onSchedule;

    initial begin
        rst = 1'b1;
        pb  = 2'b11;

        // Reset with buttons held: everything quiet, then a qualified press on both.
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("rstLevelZero",  level, 2'b00);
            checkOutput("rstPulsesZero", press | rel | rep, 2'b00);
        end
        rst = 1'b0;
        stepCycle();
        checkOutput("postRstZero", level | press | rel | rep, 2'b00);
        waitPulse(1'b0, 2'b11, 13, lat, found);
        checkValue("rstPressFound", found, 1);
        checkValue("rstPressLatency", lat + 1, 12);
        checkOutput("rstPressBoth", press, 2'b11);
        checkOutput("rstLevelBoth", level, 2'b11);
        stepCycle();
        checkOutput("rstPressWidth", press, 2'b00);
        applyStimulus(1'b0, 2'b00, 20);
        checkOutput("releasedAfterRst", level, 2'b00);

        // Bounce on ch0: 6-cycle segments never span three sample ticks.
        cntP = 0; cntR = 0;
        for (int i = 0; i < 60; i++) begin
            pb = ((i / 6) % 2 == 0) ? 2'b01 : 2'b00;
            stepCycle();
            if (press[0]) cntP++;
            if (rel[0])   cntR++;
            if (level[0]) cntP += 100;
        end
        checkValue("bouncePress",   cntP, 0);
        checkValue("bounceRelease", cntR, 0);
        applyStimulus(1'b0, 2'b00, 16);

        // Clean press and release on ch0.
        pb = 2'b01;
        waitPulse(1'b0, 2'b01, 14, lat, found);
        checkValue("cleanPressFound", found, 1);
        checkOutput("cleanPress", press, 2'b01);
        stepCycle();
        checkOutput("cleanPressWidth", press, 2'b00);
        cntP = 0;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            if (press[0]) cntP++;
        end
        checkValue("cleanSinglePress", cntP, 0);
        pb = 2'b00;
        waitPulse(1'b1, 2'b01, 14, lat, found);
        checkValue("cleanReleaseFound", found, 1);
        checkOutput("cleanRelease", rel, 2'b01);
        stepCycle();
        checkOutput("cleanReleaseWidth", rel, 2'b00);
        applyStimulus(1'b0, 2'b00, 16);

        // Long hold on ch1: first repeat 5 ticks (20 cycles) after press, then every 2 ticks.
        pb = 2'b10;
        waitPulse(1'b0, 2'b10, 14, lat, found);
        checkValue("holdPressFound", found, 1);
        checkOutput("holdPressNoRepeat", rep, 2'b00);
        repCount = 0;
        for (int off = 1; off <= 240; off++) begin
            stepCycle();
            if (rep[1]) begin
                repCount++;
                onSchedule = (off >= HT * TD) && (((off - HT * TD) % (RT * TD)) == 0);
                checkValue("repeatOnSchedule", onSchedule, 1);
                checkOutput("repeatNotWithEdge", (press | rel) & rep, 2'b00);
            end
        end
        checkValue("repeatCount", repCount, 28);
        pb = 2'b00;
        waitPulse(1'b1, 2'b10, 14, lat, found);
        checkValue("holdReleaseFound", found, 1);
        checkOutput("releaseNoRepeat", rep, 2'b00);
        applyStimulus(1'b0, 2'b00, 16);

        // Simultaneous press on both channels, held into repeat, then reset mid-hold.
        pb = 2'b11;
        waitPulse(1'b0, 2'b11, 14, lat, found);
        checkValue("simPressFound", found, 1);
        checkOutput("simPressBoth", press, 2'b11);
        applyStimulus(1'b0, 2'b11, 30);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            stepCycle();
            checkOutput("midRstZero", level | press | rel | rep, 2'b00);
        end
        rst = 1'b0;
        waitPulse(1'b0, 2'b11, 14, lat, found);
        checkValue("reQualifiedPress", found, 1);
        checkOutput("reQualifiedBoth", press, 2'b11);
        applyStimulus(1'b0, 2'b00, 20);

        // Random button activity of mixed durations, checked cycle by cycle.
        holdLeft = 0;
        for (int i = 0; i < 400; i++) begin
            if (holdLeft == 0) begin
                pb       = 2'($urandom_range(0, 3));
                holdLeft = $urandom_range(1, 40);
            end
            holdLeft--;
            stepCycle();
        end

        checkValue("repeatDisabledNeverFires", sawRep0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
